mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
- Sequential select generator that sits directly upstream of the team's 2:1 mux (`MUX_2_1`) and drives that mux's SEL input.
- Takes a raw board pushbutton, synchronizes and debounces it, and toggles SEL on each debounced press (manual mode).
- Alternatively, toggles SEL automatically every AUTO_PERIOD cycles (auto mode).
- Provides a freeze control and a one-cycle change strobe for downstream logging/LEDs.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced button follows the synchronized input. Legal range ≥ 2.
- AUTO_PERIOD, 8: cycles between SEL toggles in auto mode. Legal range ≥ 2.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST_N  input  1  reset; one clock; reset is asynchronous and active-low
- BTN  input  1  raw pushbutton, asynchronous to CLK, bouncy
- MODE  input  1  synchronous; 0 = manual toggle, 1 = auto toggle
- HOLD  input  1  synchronous; 1 freezes SEL and the auto counter
- SEL  output  1  registered select to the 2:1 mux
- SEL_CHG  output  1  registered; high for exactly one cycle when SEL has just taken a new value
- BTN_DB  output  1  registered debounced button level

Behaviour:
- Reset (RST_N low, takes effect immediately with no clock edge needed):
  - SEL=0, SEL_CHG=0, BTN_DB=0.
  - Both synchronizer flops=0, debounce counter=0, edge-detect flop=0, period counter=0, state=MANUAL.
  - Asserting reset mid-count or mid-press discards all progress; nothing is pending after release.
- Synchronizer: 2 flops, BTN → s1 → s2. BTN sampled high at edge k gives s2=1 after edge k+1.
- Debounce (counter width $clog2(DEBOUNCE_CYCLES)):
  - s2 == BTN_DB: counter cleared to 0.
  - s2 != BTN_DB and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != BTN_DB and counter == DEBOUNCE_CYCLES-1: BTN_DB ← s2, counter ← 0.
  - Any bounce back to the BTN_DB level before the terminal count restarts the count from 0.
  - Latency: BTN first sampled high at edge 1 → BTN_DB=1 after edge DEBOUNCE_CYCLES+2.
- Press detect: edge-detect flop holds the previous BTN_DB. press = BTN_DB & ~prev, so it is valid the cycle after BTN_DB rises. Release (falling BTN_DB) never toggles.
- FSM, two states, MODE sampled every edge:
  - MANUAL: MODE=1 → AUTO. On the transition edge the period counter clears to 0 and SEL is unchanged.
  - AUTO: MODE=0 → MANUAL. On the transition edge SEL is unchanged and the period counter is don't-care (cleared on the next AUTO entry).
- MANUAL, HOLD=0: press → SEL inverts at the edge where press=1. Net latency: BTN sampled high at edge 1 → SEL toggles at edge DEBOUNCE_CYCLES+3.
- AUTO, HOLD=0 (period counter width $clog2(AUTO_PERIOD)):
  - Period counter increments each edge.
  - At count AUTO_PERIOD-1: SEL inverts and the counter wraps to 0.
  - Presses are ignored.
- HOLD=1: SEL and the period counter hold their values; presses occurring while HOLD=1 are dropped, not queued. Debounce logic keeps running regardless of HOLD or MODE.
- SEL_CHG: registered alongside SEL. It is 1 in exactly the cycles where SEL differs from its previous value, and 0 otherwise, including the first cycle after reset.
- Simultaneous events:
  - MODE change on the same edge as a press or period terminal count: the new state's rule applies from the next edge, and the current edge uses the current state.
  - HOLD overrides everything except reset.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_PERIOD=3 unless noted):
- Clean press, MANUAL: BTN 0→1 sampled at edge 1 and held → BTN_DB=1 after edge 6; SEL 0→1 after edge 7; SEL_CHG=1 for that single cycle only. Then release BTN → BTN_DB=0 four cycles after s2 falls; SEL stays 1.
- Bounce rejection: BTN high for 3 cycles, low 1 cycle, high 3 cycles, then low → BTN_DB never rises; SEL=0 and SEL_CHG=0 throughout.
- Auto toggle: MODE=1 from reset release, HOLD=0 → SEL sequence per cycle 0,0,0,1,1,1,0,0,0. SEL_CHG pulses one cycle at each change. Clean presses during this have no effect.
- Hold: in AUTO with counter=1, HOLD=1 for 5 cycles → SEL constant and no SEL_CHG. After HOLD=0, the toggle occurs 2 cycles later. A clean press completing during HOLD in MANUAL → no toggle after release of HOLD.
- Async reset mid-operation: in AUTO with SEL=1 and counter=2, pull RST_N low between clock edges → SEL=0 and SEL_CHG=0 immediately. After RST_N=1, state=MANUAL and SEL stays 0 with MODE=0.
- Mode switch: MANUAL with SEL=1, set MODE=1 → counter cleared, SEL stays 1 for 3 cycles then toggles to 0. Set MODE=0 mid-period → SEL frozen until a clean press.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// Select generator for the downstream 2:1 mux: toggles SEL on debounced button presses
// (manual mode) or every AUTO_PERIOD cycles (auto mode), with a freeze control.
module mux_sel_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned AUTO_PERIOD     = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    input  logic MODE,
    input  logic HOLD,
    output logic SEL,
    output logic SEL_CHG,
    output logic BTN_DB
);

    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PerW = $clog2(AUTO_PERIOD);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PerW-1:0] PerLast = PerW'(AUTO_PERIOD - 1);

    typedef enum logic [0:0] {StManual, StAuto} state_e;

    state_e          state_q, state_d;
    logic            s1_q, s2_q;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            prev_q;
    logic [PerW-1:0] per_cnt_q, per_cnt_d;
    logic            sel_q, sel_d;
    logic            sel_chg_q, sel_chg_d;
    logic            press;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StManual;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_cnt_q  <= '0;
            btn_db_q  <= 1'b0;
            prev_q    <= 1'b0;
            per_cnt_q <= '0;
            sel_q     <= 1'b0;
            sel_chg_q <= 1'b0;
        end else begin
            s1_q      <= BTN;
            s2_q      <= s1_q;
            db_cnt_q  <= db_cnt_d;
            btn_db_q  <= btn_db_d;
            prev_q    <= btn_db_q;
            per_cnt_q <= per_cnt_d;
            sel_q     <= sel_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    // Debounce runs independently of MODE and HOLD.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (s2_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            btn_db_d = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign press = btn_db_q & ~prev_q;

    // HOLD freezes the mode transition too, so the counter clear on AUTO entry is never lost.
    always_comb begin
        state_d = state_q;
        if (!HOLD) begin
            unique case (state_q)
                StManual: if (MODE)  state_d = StAuto;
                StAuto:   if (!MODE) state_d = StManual;
                default:  state_d = StManual;
            endcase
        end
    end

    always_comb begin
        sel_d     = sel_q;
        per_cnt_d = per_cnt_q;
        if (!HOLD) begin
            unique case (state_q)
                StManual: begin
                    if (press) sel_d = ~sel_q;
                    if (MODE)  per_cnt_d = '0;
                end
                StAuto: begin
                    if (per_cnt_q == PerLast) begin
                        sel_d     = ~sel_q;
                        per_cnt_d = '0;
                    end else begin
                        per_cnt_d = per_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        sel_chg_d = sel_d ^ sel_q;
    end

    assign SEL     = sel_q;
    assign SEL_CHG = sel_chg_q;
    assign BTN_DB  = btn_db_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with DEBOUNCE_CYCLES=4, AUTO_PERIOD=3.
module tb_mux_sel_sequencer;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic BTN = 1'b0;
    logic MODE = 1'b0;
    logic HOLD = 1'b0;
    logic SEL, SEL_CHG, BTN_DB;

    int n_pass = 0;
    int n_total = 0;

    mux_sel_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (3)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BTN    (BTN),
        .MODE   (MODE),
        .HOLD   (HOLD),
        .SEL    (SEL),
        .SEL_CHG(SEL_CHG),
        .BTN_DB (BTN_DB)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Called 1 unit after an edge; next edge after release is edge 1.
    task automatic do_reset();
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    initial begin
        logic [13:0] bounce;
        logic [10:0] auto_sel;
        logic [10:0] auto_chg;
        bounce   = 14'b00000001110111;
        auto_sel = 11'b11000111000;
        auto_chg = 11'b01001001000;

        // Reset state
        #1 RST_N = 1'b0;
        #2;
        check("rst_sel", SEL, 1'b0);
        check("rst_chg", SEL_CHG, 1'b0);
        check("rst_db", BTN_DB, 1'b0);
        tick(1);
        RST_N = 1'b1;

        // Clean press in MANUAL
        BTN = 1'b1;
        tick(5);
        check("press_db_e5", BTN_DB, 1'b0);
        tick(1);
        check("press_db_e6", BTN_DB, 1'b1);
        check("press_sel_e6", SEL, 1'b0);
        tick(1);
        check("press_sel_e7", SEL, 1'b1);
        check("press_chg_e7", SEL_CHG, 1'b1);
        tick(1);
        check("press_sel_e8", SEL, 1'b1);
        check("press_chg_e8", SEL_CHG, 1'b0);
        BTN = 1'b0;
        tick(5);
        check("rel_db_e13", BTN_DB, 1'b1);
        tick(1);
        check("rel_db_e14", BTN_DB, 1'b0);
        check("rel_sel_e14", SEL, 1'b1);
        tick(2);
        check("rel_sel_e16", SEL, 1'b1);
        check("rel_chg_e16", SEL_CHG, 1'b0);

        // Bounce rejection
        do_reset();
        for (int i = 0; i < 14; i++) begin
            BTN = bounce[i];
            tick(1);
            check($sformatf("bounce_db_%0d", i), BTN_DB, 1'b0);
            check($sformatf("bounce_sel_%0d", i), SEL, 1'b0);
            check($sformatf("bounce_chg_%0d", i), SEL_CHG, 1'b0);
        end

        // Auto toggle from reset release; press during AUTO is ignored
        MODE = 1'b1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i == 1) BTN = 1'b1;
            tick(1);
            check($sformatf("auto_sel_e%0d", i + 1), SEL, auto_sel[i]);
            check($sformatf("auto_chg_e%0d", i + 1), SEL_CHG, auto_chg[i]);
        end

        // Hold in AUTO with counter=1
        BTN = 1'b0;
        HOLD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check($sformatf("hold_sel_%0d", i), SEL, 1'b1);
            check($sformatf("hold_chg_%0d", i), SEL_CHG, 1'b0);
        end
        HOLD = 1'b0;
        tick(1);
        check("unhold_sel_1", SEL, 1'b1);
        tick(1);
        check("unhold_sel_2", SEL, 1'b0);
        check("unhold_chg_2", SEL_CHG, 1'b1);

        // Bring to SEL=1, counter=2, then async reset between edges
        tick(3);
        check("pre_rst_sel", SEL, 1'b1);
        tick(2);
        RST_N = 1'b0;
        #1;
        check("async_rst_sel", SEL, 1'b0);
        check("async_rst_chg", SEL_CHG, 1'b0);
        MODE = 1'b0;
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("post_rst_sel_%0d", i), SEL, 1'b0);
        end

        // Press completing during HOLD in MANUAL is dropped
        do_reset();
        HOLD = 1'b1;
        BTN = 1'b1;
        tick(8);
        check("hold_man_db", BTN_DB, 1'b1);
        check("hold_man_sel", SEL, 1'b0);
        HOLD = 1'b0;
        tick(3);
        check("hold_man_sel_after", SEL, 1'b0);
        check("hold_man_chg_after", SEL_CHG, 1'b0);

        // Mode switch: MANUAL with SEL=1 -> AUTO -> back to MANUAL mid-period
        BTN = 1'b0;
        do_reset();
        BTN = 1'b1;
        tick(7);
        check("ms_sel_e7", SEL, 1'b1);
        BTN = 1'b0;
        MODE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("ms_auto_sel_%0d", i), SEL, 1'b1);
        end
        tick(1);
        check("ms_auto_toggle", SEL, 1'b0);
        check("ms_auto_chg", SEL_CHG, 1'b1);
        tick(1);
        MODE = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check($sformatf("ms_frozen_sel_%0d", i), SEL, 1'b0);
        end
        BTN = 1'b1;
        tick(6);
        check("ms_press_sel_e6", SEL, 1'b0);
        tick(1);
        check("ms_press_sel_e7", SEL, 1'b1);
        check("ms_press_chg_e7", SEL_CHG, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
